// File: rtl/serial_pkg.sv
// Shared state encodings, default parameters and counter sizing helper for the
// serial transmitter.
package serial_pkg;

    localparam int SERIAL_DATA_W = 8;
    localparam int SERIAL_CLKDIV = 4;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_baud_cnt.sv
// Bit-period divider: counts 0..CLKDIV-1 while enabled and pulses bit_end on the last count.
// Zero latency on bit_end; no backpressure, clr has priority over en.
module serial_baud_cnt
    import serial_pkg::*;
#(
    parameter int CLKDIV = SERIAL_CLKDIV
) (
    input  logic aclk,
    input  logic arstn,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = cnt_w(CLKDIV);

    logic [CW-1:0] count;

    assign bit_end = en && (count == CW'(CLKDIV - 1));

    // With CLKDIV=1 bit_end fires on every enabled cycle, so count never leaves 0.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            count <= '0;
        end else if (clr || bit_end) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start, DATA_W bits LSB first, optional even parity
// (SERIAL_TX_PARITY_EN), stop; first start-bit cycle follows the handshake, in_ready low while a frame runs.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W = SERIAL_DATA_W,
    parameter int CLKDIV = SERIAL_CLKDIV
) (
    input  logic              aclk,
    input  logic              arstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              txd,
    output logic              busy
);

    localparam int BW = cnt_w(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [BW-1:0]     bitcnt;
    logic              bit_end;
    logic              cnt_en;
`ifdef SERIAL_TX_PARITY_EN
    logic              par;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign busy      = !in_ready;
    assign cnt_en    = (state != ST_IDLE);
    assign shreg_nxt = shreg >> 1;

    serial_baud_cnt #(
        .CLKDIV (CLKDIV)
    ) u_baud (
        .aclk    (aclk),
        .arstn   (arstn),
        .en      (cnt_en),
        .clr     (!cnt_en),
        .bit_end (bit_end)
    );

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state  <= ST_IDLE;
            txd    <= 1'b1;
            shreg  <= '0;
            bitcnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (in_valid) begin
                        shreg <= in_data;
`ifdef SERIAL_TX_PARITY_EN
                        par   <= ^in_data;
`endif
                        state <= ST_START;
                        txd   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state  <= ST_DATA;
                        txd    <= shreg[0];
                        bitcnt <= '0;
                    end
                end
                ST_DATA: begin
                    // txd is registered, so it takes the bit that lands in shreg[0] after this shift.
                    if (bit_end) begin
                        shreg <= shreg_nxt;
                        if (bitcnt == BW'(DATA_W - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                            state <= ST_PARITY;
                            txd   <= par;
`else
                            state <= ST_STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bitcnt <= bitcnt + BW'(1);
                            txd    <= shreg_nxt[0];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        state <= ST_IDLE;
                        txd   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/CLKDIV=4 instance driven from a frame table and a
// 4-bit/CLKDIV=1 instance for the single-cycle-bit case.
module tb_serial_tx;

    logic       aclk = 1'b0;
    logic       arstn = 1'b0;

    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [7:0] a_data = 8'h00;
    logic       a_txd;
    logic       a_busy;

    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [3:0] b_data = 4'h0;
    logic       b_txd;
    logic       b_busy;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    serial_tx #(.DATA_W(8), .CLKDIV(4)) u_dut_a (
        .aclk     (aclk),
        .arstn    (arstn),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .in_data  (a_data),
        .txd      (a_txd),
        .busy     (a_busy)
    );

    serial_tx #(.DATA_W(4), .CLKDIV(1)) u_dut_b (
        .aclk     (aclk),
        .arstn    (arstn),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_data  (b_data),
        .txd      (b_txd),
        .busy     (b_busy)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] noise;
        bit         hold;
        logic [9:0] exp;   // bit i = i-th transmitted bit of the frame without parity
        logic       par;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    // Entered at a falling edge with the transmitter idle; returns at the first idle cycle after stop.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] noise, input bit hold,
                             input logic [9:0] exp, input logic par, input string nm);
        logic eb;
        int   nb;
        check($sformatf("%s_ready_pre", nm), a_ready, 1'b1);
        a_valid = 1'b1;
        a_data  = d;
        @(negedge aclk);
        a_data  = noise;
        a_valid = hold;
`ifdef SERIAL_TX_PARITY_EN
        nb = 11;
`else
        nb = 10;
`endif
        for (int i = 0; i < nb; i++) begin
`ifdef SERIAL_TX_PARITY_EN
            eb = (i < 9) ? exp[i] : ((i == 9) ? par : 1'b1);
`else
            eb = exp[i];
`endif
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_bit%0d_cyc%0d_txd", nm, i, c), a_txd, eb);
                check($sformatf("%s_bit%0d_cyc%0d_busy", nm, i, c), a_busy, 1'b1);
                @(negedge aclk);
            end
        end
        check($sformatf("%s_idle_txd", nm), a_txd, 1'b1);
        check($sformatf("%s_idle_ready", nm), a_ready, 1'b1);
        check($sformatf("%s_idle_busy", nm), a_busy, 1'b0);
    endtask

    initial begin
        logic [6:0] sb;
        int         nbb;

        vt[0] = '{8'hA5, 8'h5A, 1'b0, 10'b1_10100101_0, 1'b0};
        vt[1] = '{8'h00, 8'hFF, 1'b1, 10'b1_00000000_0, 1'b0};
        vt[2] = '{8'hFF, 8'h00, 1'b0, 10'b1_11111111_0, 1'b0};
        vt[3] = '{8'h07, 8'hF8, 1'b0, 10'b1_00000111_0, 1'b1};
        vt[4] = '{8'h03, 8'hFC, 1'b0, 10'b1_00000011_0, 1'b0};

        // Reset held with in_valid asserted: nothing may start.
        arstn   = 1'b0;
        a_valid = 1'b1;
        a_data  = 8'hA5;
        b_valid = 1'b1;
        b_data  = 4'h6;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check($sformatf("rst%0d_txd", i), a_txd, 1'b1);
            check($sformatf("rst%0d_ready", i), a_ready, 1'b1);
            check($sformatf("rst%0d_busy", i), a_busy, 1'b0);
            check($sformatf("rst%0d_b_txd", i), b_txd, 1'b1);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        arstn   = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("post_rst_txd", a_txd, 1'b1);
        check("post_rst_busy", a_busy, 1'b0);

        for (int v = 0; v < 5; v++) begin
            run_frame(vt[v].data, vt[v].noise, vt[v].hold, vt[v].exp, vt[v].par,
                      $sformatf("vec%0d", v));
        end
        a_valid = 1'b0;
        @(negedge aclk);

        // Reset asserted during data bit 3 of 0x3C must clear the line without a clock edge.
        a_valid = 1'b1;
        a_data  = 8'h3C;
        @(negedge aclk);
        a_valid = 1'b0;
        repeat (16) @(negedge aclk);
        check("mid_bit3_txd", a_txd, 1'b1);
        check("mid_bit3_busy", a_busy, 1'b1);
        arstn = 1'b0;
        #1;
        check("mid_rst_txd", a_txd, 1'b1);
        check("mid_rst_busy", a_busy, 1'b0);
        check("mid_rst_ready", a_ready, 1'b1);
        @(negedge aclk);
        @(negedge aclk);
        arstn = 1'b1;
        @(negedge aclk);
        check("mid_after_busy", a_busy, 1'b0);
        run_frame(8'h81, 8'h7E, 1'b0, 10'b1_10000001_0, 1'b0, "after_rst");

        // CLKDIV=1, DATA_W=4, 0x6: one cycle per bit.
`ifdef SERIAL_TX_PARITY_EN
        sb  = 7'b1_0_0110_0;
        nbb = 7;
`else
        sb  = 7'b0_1_0110_0;
        nbb = 6;
`endif
        check("b_ready_pre", b_ready, 1'b1);
        b_valid = 1'b1;
        b_data  = 4'h6;
        @(negedge aclk);
        b_valid = 1'b0;
        b_data  = 4'h9;
        for (int i = 0; i < nbb; i++) begin
            check($sformatf("b_bit%0d_txd", i), b_txd, sb[i]);
            check($sformatf("b_bit%0d_busy", i), b_busy, 1'b1);
            @(negedge aclk);
        end
        check("b_idle_txd", b_txd, 1'b1);
        check("b_idle_ready", b_ready, 1'b1);
        @(negedge aclk);
        check("b_still_idle_busy", b_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial transmitter that produces the single-bit stream captured downstream by a flop-based serial receiver.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits an asynchronous-style frame on txd: start bit, data LSB first, optional parity, stop bit.
- Each bit is held for CLKDIV clock cycles.
- Sits at the transmit end of the block-level serial link used in the example testbenches.

Parameters:
DATA_W, 8, data bits per frame (1..32)
CLKDIV, 4, clock cycles per serial bit (>=1)

Ports:
aclk  input  1  clock, all logic on rising edge
arstn  input  1  asynchronous active-low reset
in_valid  input  1  in_data holds a word to send
in_ready  output  1  transmitter can accept a word this cycle
in_data  input  DATA_W  word to serialise
txd  output  1  serial line, idle high
busy  output  1  frame in progress

Behaviour:
- Clock and reset (already decided): one clock, aclk. arstn is asynchronous and active-low. Assertion forces registered state immediately, without waiting for a clock edge.
- Reset values: state=IDLE, txd=1, busy=0, in_ready=1, divider and bit counters=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY (only with feature), STOP.
- IDLE:
  - txd=1, in_ready=1, busy=0.
  - On in_valid && in_ready, latch in_data into the shift register and go to START.
- Bit timing:
  - Every non-IDLE state lasts exactly CLKDIV cycles, counted by the divider counter (0..CLKDIV-1).
  - The state advances when the divider reaches CLKDIV-1.
- START: txd=0.
- DATA:
  - txd = shift register bit 0; shift right at each bit boundary.
  - Bit counter runs 0..DATA_W-1.
  - Leave after DATA_W bits: to PARITY if enabled, else to STOP.
- STOP: txd=1. Return to IDLE after CLKDIV cycles.
- Output timing:
  - txd is registered and changes on the clock edge at which the state is entered.
  - The first start-bit cycle is the cycle after the handshake.
- in_ready and busy:
  - in_ready = (state==IDLE), registered-state decode with no combinational path from in_valid.
  - busy = !in_ready.
- Frame length: (DATA_W+2)*CLKDIV cycles, or (DATA_W+3)*CLKDIV with parity.
- Back-to-back: the next handshake can occur on the first IDLE cycle after STOP. The minimum gap between frames is one idle cycle with txd=1.
- Input stability: in_data changes while busy are ignored. The word is latched only at the handshake.
- in_valid while busy: no effect. The word waits until in_ready; the protocol requires the source to hold it.
- CLKDIV=1: one cycle per bit; the divider counter is tied to 0.
- Reset mid-frame: txd returns to 1 at once and the partial frame is abandoned. The first transmission after release starts from IDLE.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - txd = even parity, the XOR of all DATA_W latched bits, held CLKDIV cycles.
  - Parity is computed at the handshake and stored.
- Undefined: no PARITY state, no parity register; DATA goes directly to STOP.

Decomposition:
- Shared package serial_pkg contains:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - default constants SERIAL_DATA_W=8, SERIAL_CLKDIV=4
  - localparam helper for counter width, max(1,$clog2(CLKDIV))
- One sub-module: serial_baud_cnt.
  - Divider counter with enable and synchronous clear.
  - Outputs a bit_end pulse when count==CLKDIV-1.
  - Same aclk/arstn.

Test Plan:
- Reset: hold arstn=0 for 5 cycles, in_valid=1 -> txd=1, in_ready=1, busy=0 throughout; no frame starts.
- Single frame, DATA_W=8, CLKDIV=4, in_data=0xA5:
  - Expected txd bits 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles.
  - busy=1 for 40 cycles; in_ready returns 1 on cycle 41.
- Back-to-back, in_valid held high with 0x00 then 0xFF:
  - Expected two frames separated by exactly one txd=1 idle cycle.
  - Second frame data bits are all 1 and not corrupted by in_data changes during frame 1.
- Reset mid-frame: assert arstn=0 during data bit 3 of 0x3C -> txd=1 within the same cycle, busy=0. After release, send 0x81 -> clean full frame.
- CLKDIV=1, DATA_W=4, in_data=0x6 -> txd 0,0,1,1,0,1 on six consecutive cycles.
- With SERIAL_TX_PARITY_EN, in_data=0x07 -> parity bit 1 after data. With in_data=0x03 -> parity bit 0. Frame is 44 cycles at CLKDIV=4.
